// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one 32-bit, fixed-latency memory bus between NUM_REQ requesters.
//   Each cycle at most one request is granted. Priority is round-robin, and a
//   requester can hold the bus through back-to-back requests by asserting its
//   lock. Each grant's response is returned one cycle later to the requester
//   that issued it.
//
// Ports
//   clk_i, rst_ni          clock; synchronous active-low reset
//   req_i, lock_i          per-requester request and lock
//   addr_i, we_i, be_i,    per-requester request fields, packed with
//   wdata_i                requester k at slice [k*W +: W]
//   gnt_o                  one-hot grant, same cycle as the request
//   rvalid_o, err_o,       one-hot response valid, response error and
//   rdata_o                broadcast read data, one cycle after the grant
//   mem_*_o                downstream request (fields are zero when idle)
//   mem_rvalid_i,          downstream response
//   mem_err_i, mem_rdata_i
module mem_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      lock_i,
  input  logic [NUM_REQ*32-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [NUM_REQ*4-1:0]    be_i,
  input  logic [NUM_REQ*32-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      rvalid_o,
  output logic                    err_o,
  output logic [31:0]             rdata_o,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic                    mem_err_i,
  input  logic [31:0]             mem_rdata_i
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] lock_own;
  logic            lock_act;
  logic            pend;
  logic [ID_W-1:0] pend_id;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic            lock_hit;
  logic [ID_W-1:0] rr_next;

  // Arbitration: the lock holder wins while it keeps requesting; otherwise
  // scan from rr_ptr upward with wrap. Everything is suppressed in reset.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    lock_hit = 1'b0;
    idx      = 0;
    cand     = '0;
    if (rst_ni) begin
      if (lock_act && req_i[lock_own]) begin
        gnt_vld  = 1'b1;
        gnt_id   = lock_own;
        lock_hit = 1'b1;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          idx  = (int'(rr_ptr) + i) % NUM_REQ;
          cand = ID_W'(idx);
          if (!gnt_vld && req_i[cand]) begin
            gnt_vld = 1'b1;
            gnt_id  = cand;
          end
        end
      end
    end
  end

  always_comb begin
    rr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Downstream mux; fields read as zero when nothing is granted.
  always_comb begin
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt_vld) begin
      gnt_o[gnt_id] = 1'b1;
      mem_req_o     = 1'b1;
      mem_addr_o    = addr_i[int'(gnt_id)*32 +: 32];
      mem_we_o      = we_i[gnt_id];
      mem_be_o      = be_i[int'(gnt_id)*4 +: 4];
      mem_wdata_o   = wdata_i[int'(gnt_id)*32 +: 32];
    end
  end

  // Grant stage -> response stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock_own <= '0;
      lock_act <= 1'b0;
      pend     <= 1'b0;
      pend_id  <= '0;
    end else if (gnt_vld) begin
      pend     <= 1'b1;
      pend_id  <= gnt_id;
      lock_own <= gnt_id;
      lock_act <= lock_i[gnt_id];
      // A locked holder keeps the round-robin position frozen.
      if (!lock_hit) begin
        rr_ptr <= rr_next;
      end
    end else begin
      pend <= 1'b0;
      // Holder went idle: the lock is released.
      if (lock_act && !req_i[lock_own]) begin
        lock_act <= 1'b0;
      end
    end
  end

  // Response: a missing downstream rvalid is reported as an error rather
  // than dropped; stray downstream responses with nothing pending are ignored.
  always_comb begin
    rvalid_o = '0;
    err_o    = 1'b0;
    rdata_o  = '0;
    if (rst_ni && pend) begin
      rvalid_o[pend_id] = 1'b1;
      err_o             = mem_err_i | ~mem_rvalid_i;
      rdata_o           = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- NUM_REQ = 2 instance ----------------
  logic [1:0]  req2, lock2, we2;
  logic [63:0] addr2, wdata2;
  logic [7:0]  be2;
  logic [1:0]  gnt2, rv2;
  logic        err2, mreq2, mwe2;
  logic [31:0] rdata2, maddr2, mwdata2;
  logic [3:0]  mbe2;
  logic        mv2, stray, suppress, err_inj;
  logic [31:0] md2;
  logic        mrv2;

  assign mrv2 = mv2 | stray;

  mem_bus_arbiter #(.NUM_REQ(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req2), .lock_i(lock2), .addr_i(addr2), .we_i(we2), .be_i(be2),
    .wdata_i(wdata2), .gnt_o(gnt2), .rvalid_o(rv2), .err_o(err2),
    .rdata_o(rdata2), .mem_req_o(mreq2), .mem_addr_o(maddr2),
    .mem_we_o(mwe2), .mem_be_o(mbe2), .mem_wdata_o(mwdata2),
    .mem_rvalid_i(mrv2), .mem_err_i(err_inj), .mem_rdata_i(md2)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Fixed one-cycle-latency memory; suppress drops the next response.
  always @(posedge clk) begin
    mv2 <= mreq2 & ~suppress;
    md2 <= data_of(maddr2);
  end

  // ---------------- NUM_REQ = 3 instance ----------------
  logic [2:0]  req3, lock3, we3;
  logic [95:0] addr3, wdata3;
  logic [11:0] be3;
  logic [2:0]  gnt3, rv3;
  logic        err3, mreq3, mwe3;
  logic [31:0] rdata3, maddr3, mwdata3;
  logic [3:0]  mbe3;
  logic        mrv3, merr3;
  logic [31:0] mrd3;

  mem_bus_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req3), .lock_i(lock3), .addr_i(addr3), .we_i(we3), .be_i(be3),
    .wdata_i(wdata3), .gnt_o(gnt3), .rvalid_o(rv3), .err_o(err3),
    .rdata_o(rdata3), .mem_req_o(mreq3), .mem_addr_o(maddr3),
    .mem_we_o(mwe3), .mem_be_o(mbe3), .mem_wdata_o(mwdata3),
    .mem_rvalid_i(mrv3), .mem_err_i(merr3), .mem_rdata_i(mrd3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; callers then drive inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prev_addr;
  logic [1:0]  prev_gnt;

  initial begin
    rst_n = 1'b0;
    req2 = 2'b11; lock2 = '0; we2 = '0; be2 = {4'hC, 4'h3};
    addr2 = {32'h0000_0200, 32'h0000_0100}; wdata2 = '0;
    stray = 1'b0; suppress = 1'b0; err_inj = 1'b0;
    req3 = '0; lock3 = '0; we3 = '0; be3 = '0; wdata3 = '0;
    addr3 = {32'h0002_0000, 32'h0001_0000, 32'h0000_0400};
    mrv3 = 1'b0; merr3 = 1'b0; mrd3 = '0;

    // Reset held with all requests asserted
    for (int k = 0; k < 3; k++) begin
      cyc(); #2;
      check("rst_gnt", gnt2, 0);
      check("rst_mem_req", mreq2, 0);
      check("rst_rvalid", rv2, 0);
    end
    cyc(); rst_n = 1'b1; #2;
    check("post_rst_gnt", gnt2, 2'b01);
    prev_gnt = 2'b01; prev_addr = 32'h100;

    // Round-robin alternation with responses one cycle behind
    for (int t = 1; t < 6; t++) begin
      cyc(); #2;
      check("rr_gnt", gnt2, (t % 2) ? 2'b10 : 2'b01);
      check("rr_addr", maddr2, (t % 2) ? 32'h200 : 32'h100);
      check("rr_rvalid", rv2, prev_gnt);
      check("rr_rdata", rdata2, data_of(prev_addr));
      check("rr_err", err2, 0);
      prev_gnt  = (t % 2) ? 2'b10 : 2'b01;
      prev_addr = (t % 2) ? 32'h200 : 32'h100;
    end
    cyc(); req2 = 2'b00; #2;
    check("rr_tail_gnt", gnt2, 0);
    check("rr_tail_rvalid", rv2, 2'b10);
    check("rr_tail_rdata", rdata2, data_of(32'h200));
    cyc(); #2;
    check("idle_rvalid", rv2, 0);
    check("idle_rdata", rdata2, 0);

    // Lock: r0 writes first, then r1 holds the bus for 4 locked requests
    cyc(); req2 = 2'b11; lock2 = 2'b10; we2 = 2'b01; wdata2[31:0] = 32'hCAFE_0001; #2;
    check("lk_first_gnt", gnt2, 2'b01);
    check("lk_we", mwe2, 1);
    check("lk_wdata", mwdata2, 32'hCAFE_0001);
    check("lk_be", mbe2, 4'h3);
    for (int j = 0; j < 4; j++) begin
      cyc(); if (j == 0) we2 = 2'b00; #2;
      check("lk_hold_gnt", gnt2, 2'b10);
      check("lk_hold_be", mbe2, 4'hC);
      if (j == 0) check("lk_wr_rvalid", rv2, 2'b01);
    end
    cyc(); lock2 = 2'b00; #2;
    check("lk_release_gnt", gnt2, 2'b10);
    cyc(); #2;
    check("lk_after_gnt", gnt2, 2'b01);
    cyc(); req2 = 2'b00; #2;
    check("lk_after_rvalid", rv2, 2'b01);
    cyc();

    // Missing response, then downstream error
    cyc(); req2 = 2'b01; addr2[31:0] = 32'h0000_1000; suppress = 1'b1; #2;
    check("miss_gnt", gnt2, 2'b01);
    cyc(); suppress = 1'b0; req2 = 2'b10; addr2[63:32] = 32'h0000_0300; #2;
    check("miss_rvalid", rv2, 2'b01);
    check("miss_err", err2, 1);
    check("miss_next_gnt", gnt2, 2'b10);
    cyc(); req2 = 2'b00; err_inj = 1'b1; #2;
    check("derr_rvalid", rv2, 2'b10);
    check("derr_err", err2, 1);
    check("derr_rdata", rdata2, data_of(32'h300));
    cyc(); err_inj = 1'b0; #2;
    check("quiet_rvalid", rv2, 0);
    check("quiet_err", err2, 0);

    // Stray downstream response with nothing pending
    cyc(); stray = 1'b1; #2;
    check("stray_rvalid", rv2, 0);
    check("stray_err", err2, 0);
    check("stray_rdata", rdata2, 0);

    // Grant r1, then reset before its response
    cyc(); stray = 1'b0; req2 = 2'b10; #2;
    check("mid_gnt", gnt2, 2'b10);
    cyc(); rst_n = 1'b0; req2 = 2'b11; #2;
    check("mid_rst_rvalid", rv2, 0);
    check("mid_rst_gnt", gnt2, 0);
    check("mid_rst_err", err2, 0);
    cyc(); rst_n = 1'b1; req2 = 2'b00; #2;
    check("post_mid_rvalid", rv2, 0);
    cyc(); req2 = 2'b11; #2;
    check("post_mid_gnt", gnt2, 2'b01);
    cyc(); req2 = 2'b00;

    // Wrap with three requesters: move rr_ptr to 1, then request {0,2}
    cyc(); req3 = 3'b001; #2;
    check("w3_setup_gnt", gnt3, 3'b001);
    cyc(); req3 = 3'b101; we3 = 3'b100; be3[11:8] = 4'h5; wdata3[95:64] = 32'h5555_AAAA; #2;
    check("w3_gnt2", gnt3, 3'b100);
    check("w3_mem_req", mreq3, 1);
    check("w3_addr", maddr3, 32'h0002_0000);
    check("w3_we", mwe3, 1);
    check("w3_be", mbe3, 4'h5);
    check("w3_wdata", mwdata3, 32'h5555_AAAA);
    check("w3_rvalid", rv3, 3'b001);
    check("w3_err", err3, 1);
    check("w3_rdata", rdata3, 0);
    cyc(); req3 = 3'b001; we3 = 3'b000; #2;
    check("w3_gnt0", gnt3, 3'b001);
    check("w3_rvalid2", rv3, 3'b100);
    cyc(); req3 = 3'b000;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
